// File: rtl/ps2_kbd_ctrl.sv
// PS/2 scan-code consumer: pops the receiver FIFO, folds E0/F0 prefixes into key events,
// tracks the held key and counts new presses. Define PS2_KBD_ASCII_EN for the ASCII lookup.
module ps2_kbd_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [7:0]       data,
    input  logic             ready,
    input  logic             overflow,
    output logic             nextdata_n,
    output logic             key_valid,
    output logic             key_make,
    output logic             key_repeat,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic             key_held,
    output logic [CNT_W-1:0] press_cnt,
    output logic             ovf_err,
    output logic [7:0]       ascii
);

    typedef enum logic [1:0] {IDLE, POP, DECODE} state_t;

    state_t     state_reg;
    logic [7:0] byte_reg;
    logic       ext_reg;
    logic       brk_reg;
    logic [7:0] held_code_reg;
    logic       held_ext_reg;

    logic is_prefix;
    logic decode_ev;
    logic held_match;

    assign is_prefix  = (byte_reg == 8'hE0) || (byte_reg == 8'hF0);
    assign decode_ev  = (state_reg == DECODE) && !is_prefix;
    assign held_match = (held_code_reg == byte_reg) && (held_ext_reg == ext_reg);

    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_reg     <= IDLE;
            byte_reg      <= 8'h00;
            ext_reg       <= 1'b0;
            brk_reg       <= 1'b0;
            held_code_reg <= 8'h00;
            held_ext_reg  <= 1'b0;
            nextdata_n    <= 1'b1;
            key_valid     <= 1'b0;
            key_make      <= 1'b0;
            key_repeat    <= 1'b0;
            key_code      <= 8'h00;
            key_ext       <= 1'b0;
            key_held      <= 1'b0;
            press_cnt     <= '0;
            ovf_err       <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (overflow) begin
                ovf_err <= 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (ready) begin
                        byte_reg   <= data;
                        nextdata_n <= 1'b0;
                        state_reg  <= POP;
                    end
                end
                POP: begin
                    nextdata_n <= 1'b1;
                    state_reg  <= DECODE;
                end
                DECODE: begin
                    state_reg <= IDLE;
                    if (byte_reg == 8'hE0) begin
                        ext_reg <= 1'b1;
                    end else if (byte_reg == 8'hF0) begin
                        brk_reg <= 1'b1;
                    end else begin
                        key_valid <= 1'b1;
                        key_code  <= byte_reg;
                        key_ext   <= ext_reg;
                        ext_reg   <= 1'b0;
                        brk_reg   <= 1'b0;
                        if (brk_reg) begin
                            key_make   <= 1'b0;
                            key_repeat <= 1'b0;
                            // Releasing some other key leaves the held key alone.
                            if (key_held && held_match) begin
                                key_held <= 1'b0;
                            end
                        end else begin
                            key_make <= 1'b1;
                            if (key_held && held_match) begin
                                key_repeat <= 1'b1;
                            end else begin
                                key_repeat    <= 1'b0;
                                held_code_reg <= byte_reg;
                                held_ext_reg  <= ext_reg;
                                key_held      <= 1'b1;
                                press_cnt     <= press_cnt + CNT_W'(1);
                            end
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef PS2_KBD_ASCII_EN
    logic       lshift_reg;
    logic       rshift_reg;
    logic [7:0] lut_char;
    logic       lut_letter;

    always_comb begin
        lut_char = 8'h00;
        case (byte_reg)
            8'h1C: lut_char = 8'h61; 8'h32: lut_char = 8'h62; 8'h21: lut_char = 8'h63;
            8'h23: lut_char = 8'h64; 8'h24: lut_char = 8'h65; 8'h2B: lut_char = 8'h66;
            8'h34: lut_char = 8'h67; 8'h33: lut_char = 8'h68; 8'h43: lut_char = 8'h69;
            8'h3B: lut_char = 8'h6A; 8'h42: lut_char = 8'h6B; 8'h4B: lut_char = 8'h6C;
            8'h3A: lut_char = 8'h6D; 8'h31: lut_char = 8'h6E; 8'h44: lut_char = 8'h6F;
            8'h4D: lut_char = 8'h70; 8'h15: lut_char = 8'h71; 8'h2D: lut_char = 8'h72;
            8'h1B: lut_char = 8'h73; 8'h2C: lut_char = 8'h74; 8'h3C: lut_char = 8'h75;
            8'h2A: lut_char = 8'h76; 8'h1D: lut_char = 8'h77; 8'h22: lut_char = 8'h78;
            8'h35: lut_char = 8'h79; 8'h1A: lut_char = 8'h7A;
            8'h45: lut_char = 8'h30; 8'h16: lut_char = 8'h31; 8'h1E: lut_char = 8'h32;
            8'h26: lut_char = 8'h33; 8'h25: lut_char = 8'h34; 8'h2E: lut_char = 8'h35;
            8'h36: lut_char = 8'h36; 8'h3D: lut_char = 8'h37; 8'h3E: lut_char = 8'h38;
            8'h46: lut_char = 8'h39;
            8'h29: lut_char = 8'h20;
            8'h5A: lut_char = 8'h0D;
            default: lut_char = 8'h00;
        endcase
    end

    assign lut_letter = (lut_char >= 8'h61) && (lut_char <= 8'h7A);

    // The character uses the shift state from before this event is applied.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            lshift_reg <= 1'b0;
            rshift_reg <= 1'b0;
            ascii      <= 8'h00;
        end else if (decode_ev) begin
            if (ext_reg) begin
                ascii <= 8'h00;
            end else if (lut_letter && (lshift_reg || rshift_reg)) begin
                ascii <= lut_char - 8'h20;
            end else begin
                ascii <= lut_char;
            end
            if (!ext_reg && byte_reg == 8'h12) begin
                lshift_reg <= !brk_reg;
            end
            if (!ext_reg && byte_reg == 8'h59) begin
                rshift_reg <= !brk_reg;
            end
        end
    end
`else
    logic unused_decode_ev;
    assign unused_decode_ev = decode_ev;
    assign ascii = 8'h00;
`endif

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Scoreboard bench for ps2_kbd_ctrl: a FIFO model feeds bytes, a stream-level key model
// predicts events, and a monitor pops expectations on every key_valid pulse.
module tb_ps2_kbd_ctrl;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             clrn = 1'b0;
    logic [7:0]       data;
    logic             ready;
    logic             overflow = 1'b0;
    logic             nextdata_n;
    logic             key_valid;
    logic             key_make;
    logic             key_repeat;
    logic [7:0]       key_code;
    logic             key_ext;
    logic             key_held;
    logic [CNT_W-1:0] press_cnt;
    logic             ovf_err;
    logic [7:0]       ascii;

    ps2_kbd_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .clrn(clrn), .data(data), .ready(ready), .overflow(overflow),
        .nextdata_n(nextdata_n), .key_valid(key_valid), .key_make(key_make),
        .key_repeat(key_repeat), .key_code(key_code), .key_ext(key_ext),
        .key_held(key_held), .press_cnt(press_cnt), .ovf_err(ovf_err), .ascii(ascii)
    );

    always #5 clk = ~clk;

    // Receiver FIFO: stimulus owns wr_ptr, the receiver model owns rd_ptr.
    logic [7:0] stim_mem [0:4095];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign ready = (rd_ptr != wr_ptr);
    assign data  = stim_mem[rd_ptr[11:0]];

    always @(posedge clk) begin
        if (!nextdata_n && rd_ptr != wr_ptr) rd_ptr <= rd_ptr + 1;
    end

    typedef struct {
        logic       make;
        logic       rep;
        logic [7:0] code;
        logic       ext;
        logic       held;
        logic [7:0] cnt;
        logic [7:0] asc;
    } ev_t;

    ev_t exp_q[$];
    int tests = 0;
    int fails = 0;
    int pop_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural key model over the byte stream.
    logic       m_ext = 0, m_brk = 0, m_held = 0, m_hext = 0, m_lsh = 0, m_rsh = 0;
    logic [7:0] m_hcode = 0;
    logic [7:0] m_cnt = 0;

    function automatic logic [7:0] ref_ascii(input logic [7:0] b, input logic sh);
        logic [7:0] letters [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                     8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                     8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                     8'h35, 8'h1A};
        logic [7:0] digits [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                    8'h3E, 8'h46};
        for (int i = 0; i < 26; i++)
            if (letters[i] == b) return (sh ? 8'd65 : 8'd97) + 8'(i);
        for (int i = 0; i < 10; i++)
            if (digits[i] == b) return 8'd48 + 8'(i);
        if (b == 8'h29) return 8'h20;
        if (b == 8'h5A) return 8'h0D;
        return 8'h00;
    endfunction

    task automatic send(input logic [7:0] b);
        ev_t ev;
        stim_mem[wr_ptr[11:0]] = b;
        wr_ptr = wr_ptr + 1;
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else begin
            ev.code = b;
            ev.ext  = m_ext;
            ev.make = !m_brk;
            ev.rep  = 0;
            if (m_brk) begin
                if (m_held && m_hcode == b && m_hext == m_ext) m_held = 0;
            end else if (m_held && m_hcode == b && m_hext == m_ext) begin
                ev.rep = 1;
            end else begin
                m_held = 1; m_hcode = b; m_hext = m_ext; m_cnt = m_cnt + 8'd1;
            end
`ifdef PS2_KBD_ASCII_EN
            ev.asc = m_ext ? 8'h00 : ref_ascii(b, m_lsh | m_rsh);
`else
            ev.asc = 8'h00;
`endif
            if (!m_ext && b == 8'h12) m_lsh = !m_brk;
            if (!m_ext && b == 8'h59) m_rsh = !m_brk;
            ev.held = m_held;
            ev.cnt  = m_cnt;
            exp_q.push_back(ev);
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_held = 0; m_hext = 0; m_lsh = 0; m_rsh = 0;
        m_hcode = 0; m_cnt = 0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (rd_ptr != wr_ptr && n < 20000) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        check({name, "_drained"}, (rd_ptr == wr_ptr) ? 1 : 0, 1);
        check({name, "_events_left"}, exp_q.size(), 0);
    endtask

    // Monitor: pops expectations on key_valid, and polices the pop strobe.
    logic prev_ndn_low = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!nextdata_n) begin
                pop_cnt++;
                check("nextdata_n_consecutive", prev_ndn_low, 0);
            end
            prev_ndn_low = !nextdata_n;
            if (key_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_key_valid", {24'h0, key_code}, 32'hFFFF_FFFF);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    $display("[TB] event code=%02h ext=%0d make=%0d rep=%0d held=%0d cnt=%0d ascii=%02h",
                             key_code, key_ext, key_make, key_repeat, key_held, press_cnt, ascii);
                    check("key_code", key_code, e.code);
                    check("key_ext", key_ext, e.ext);
                    check("key_make", key_make, e.make);
                    check("key_repeat", key_repeat, e.rep);
                    check("key_held", key_held, e.held);
                    check("press_cnt", press_cnt, e.cnt);
                    check("ascii", ascii, e.asc);
                end
            end
        end
    end

    initial begin
        logic [7:0] pool [12] = '{8'h1C, 8'h32, 8'h21, 8'h12, 8'h59, 8'h29, 8'h5A, 8'h45,
                                  8'h16, 8'hE0, 8'hF0, 8'h75};
        repeat (3) @(negedge clk);
        check("rst_nextdata_n", nextdata_n, 1);
        check("rst_key_valid", key_valid, 0);
        check("rst_key_make", key_make, 0);
        check("rst_key_repeat", key_repeat, 0);
        check("rst_key_code", key_code, 0);
        check("rst_key_ext", key_ext, 0);
        check("rst_key_held", key_held, 0);
        check("rst_press_cnt", press_cnt, 0);
        check("rst_ovf_err", ovf_err, 0);
        check("rst_ascii", ascii, 0);
        clrn = 1'b1;
        @(negedge clk);

        send(8'h1C); send(8'hF0); send(8'h1C);
        drain("make_release");
        check("pops_make_release", pop_cnt, 3);

        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        drain("extended");

        send(8'h1C); send(8'h1C); send(8'h1C);
        drain("typematic");
        check("ovf_err_before", ovf_err, 0);

        overflow = 1'b1;
        @(negedge clk);
        overflow = 1'b0;
        @(negedge clk);
        check("ovf_err_set", ovf_err, 1);

        send(8'h12); send(8'h1C); send(8'hF0); send(8'h12); send(8'h32);
        drain("shift");

        for (int i = 0; i < 256; i++) send((i % 2 == 0) ? 8'h1C : 8'h32);
        drain("wrap");

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) send(8'($urandom_range(0, 255)));
            else send(pool[$urandom_range(0, 11)]);
        end
        send(8'h1C);
        drain("random");
        check("ovf_err_sticky", ovf_err, 1);
        check("pop_total", pop_cnt, wr_ptr);

        send(8'hE0); send(8'hF0);
        drain("prefix_only");
        clrn = 1'b0;
        @(negedge clk);
        clrn = 1'b1;
        model_reset();
        check("ovf_err_cleared", ovf_err, 0);
        check("press_cnt_cleared", press_cnt, 0);
        send(8'h1C);
        drain("after_reset");
        check("pop_total_final", pop_cnt, wr_ptr);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
